// File: rtl/risc_datapath.sv
// risc_datapath: PC, IR, operand data register (DR), accumulator (AC), ALU and
// memory-port drive for the 8-state accumulator machine. The controller drives
// the strobes. The datapath returns the opcode and the zero flag.
// Instruction word layout: {opcode[OPW-1:0], operand_addr[AW-1:0]}.
//
// Strobe semantics: there is no valid/ready handshake on this block. Every
// strobe is a single-cycle command. It is sampled at the rising edge of clk,
// and the loaded value appears on the outputs right after that edge. The memory
// must return mem_rdata combinationally while mem_re is high. The write data is
// taken from mem_wdata while mem_we is high.
module risc_datapath #(
  parameter int DW  = 8,
  parameter int AW  = 5,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sel,
  input  logic           rd,
  input  logic           ld_ir,
  input  logic           inc_pc,
  input  logic           ld_ac,
  input  logic           ld_pc,
  input  logic           wr,
  input  logic           data_e,
  input  logic [DW-1:0]  mem_rdata,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_re,
  output logic           mem_we,
  output logic [OPW-1:0] opcode,
  output logic           zero,
  output logic [AW-1:0]  pc,
  output logic [DW-1:0]  ac
);

  // An instruction must exactly fill one data word.
  if (DW != OPW + AW) begin : g_bad_width
    $error("risc_datapath: DW must equal OPW + AW");
  end

  // Opcode map
  localparam logic [OPW-1:0] OP_HLT = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);
  localparam logic [OPW-1:0] OP_STO = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);

  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] dr_q;
  logic [DW-1:0] ac_q;

  logic [OPW-1:0] ir_op;
  logic [AW-1:0]  ir_addr;
  logic [DW-1:0]  alu_result;
  logic [AW-1:0]  pc_next;
  logic           ac_zero;
  logic           dr_load;

  assign ir_op   = ir_q[DW-1:AW];
  assign ir_addr = ir_q[AW-1:0];
  assign ac_zero = (ac_q == '0);

  // DR captures operand fetches only. These are reads addressed by the IR,
  // excluding the instruction fetch itself. DR then holds the operand for
  // the later ALU and store states.
  assign dr_load = rd && !sel && !ld_ir;

  // Memory port and controller-facing outputs.
  always_comb begin
    mem_addr  = sel ? pc_q : ir_addr;
    mem_re    = rd;
    mem_we    = wr;
    mem_wdata = data_e ? ac_q : '0;
    opcode    = ir_op;
    zero      = ac_zero;
    pc        = pc_q;
    ac        = ac_q;
  end

  // ALU: the operation is chosen by the opcode currently held in IR.
  // HLT, SKZ, STO and JMP leave the accumulator unchanged.
  always_comb begin
    alu_result = ac_q;
    case (ir_op)
      OP_ADD:  alu_result = ac_q + dr_q;
      OP_AND:  alu_result = ac_q & dr_q;
      OP_XOR:  alu_result = ac_q ^ dr_q;
      OP_LDA:  alu_result = dr_q;
      OP_HLT,
      OP_SKZ,
      OP_STO,
      OP_JMP:  alu_result = ac_q;
      default: alu_result = ac_q;
    endcase
  end

  // Next PC: a jump has priority over an increment. A taken SKZ skips one
  // word. The arithmetic wraps modulo 2^AW.
  always_comb begin
    pc_next = pc_q;
    if (ld_pc) begin
      pc_next = ir_addr;
    end else if (inc_pc) begin
      if (ir_op == OP_SKZ && ac_zero) begin
        pc_next = pc_q + AW'(2);
      end else begin
        pc_next = pc_q + AW'(1);
      end
    end
  end

  // Program counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_next;
    end
  end

  // Instruction register. A reset value of 0 decodes as HLT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= '0;
    end else if (ld_ir) begin
      ir_q <= mem_rdata;
    end
  end

  // Operand data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dr_q <= '0;
    end else if (dr_load) begin
      dr_q <= mem_rdata;
    end
  end

  // Accumulator. The ALU reads the pre-edge IR, so a simultaneous ld_ir
  // does not change the operation that is applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_q <= '0;
    end else if (ld_ac) begin
      ac_q <= alu_result;
    end
  end

endmodule

// File: tb/tb_risc_datapath.sv
// Directed testbench for risc_datapath. Each task drives one scenario and
// checks the outputs against hand-computed values.
module tb_risc_datapath;

  localparam int DW  = 8;
  localparam int AW  = 5;
  localparam int OPW = 3;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           sel, rd, ld_ir, inc_pc, ld_ac, ld_pc, wr, data_e;
  logic [DW-1:0]  mem_rdata;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_re, mem_we;
  logic [OPW-1:0] opcode;
  logic           zero;
  logic [AW-1:0]  pc;
  logic [DW-1:0]  ac;

  int n_checks = 0;
  int n_fail   = 0;

  risc_datapath #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .rd        (rd),
    .ld_ir     (ld_ir),
    .inc_pc    (inc_pc),
    .ld_ac     (ld_ac),
    .ld_pc     (ld_pc),
    .wr        (wr),
    .data_e    (data_e),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .opcode    (opcode),
    .zero      (zero),
    .pc        (pc),
    .ac        (ac)
  );

  // Watchdog: no scenario should take anywhere near this long.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sel = 1'b0; rd = 1'b0; ld_ir = 1'b0; inc_pc = 1'b0;
    ld_ac = 1'b0; ld_pc = 1'b0; wr = 1'b0; data_e = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic load_ir(input logic [DW-1:0] w);
    idle();
    sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; mem_rdata = w;
    tick();
    idle();
  endtask

  task automatic load_dr(input logic [DW-1:0] d);
    idle();
    rd = 1'b1; mem_rdata = d;
    tick();
    idle();
  endtask

  // Set AC through an LDA: IR=LDA, DR=value, then ld_ac.
  task automatic set_ac(input logic [DW-1:0] v);
    load_ir(8'hA0);
    load_dr(v);
    ld_ac = 1'b1;
    tick();
    idle();
  endtask

  // Set PC through a JMP.
  task automatic set_pc(input logic [AW-1:0] a);
    load_ir({3'd7, a});
    ld_pc = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    set_ac(8'h3C);
    set_pc(5'd7);
    n_checks++;
    if (pc !== 5'd7 || ac !== 8'h3C) begin
      n_fail++;
      $display("FAIL pre_reset: pc=%0d ac=%h expected pc=7 ac=3c", pc, ac);
    end
    // Assert reset between edges; the clear must not wait for a clock.
    #2;
    rd = 1'b1; wr = 1'b1; data_e = 1'b1; sel = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (pc !== 5'd0 || ac !== 8'h00 || opcode !== 3'd0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: pc=%0d ac=%h op=%0d zero=%b expected 0 00 0 1",
               pc, ac, opcode, zero);
    end
    n_checks++;
    if (mem_addr !== 5'd0 || mem_wdata !== 8'h00 || mem_re !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_port: addr=%0d wdata=%h re=%b we=%b expected 0 00 1 1",
               mem_addr, mem_wdata, mem_re, mem_we);
    end
    tick();
    idle();
    rst = 1'b0;
    #1;
    n_checks++;
    if (pc !== 5'd0 || ac !== 8'h00 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: pc=%0d ac=%h re=%b we=%b expected 0 00 0 0",
               pc, ac, mem_re, mem_we);
    end
  endtask

  task automatic test_lda();
    idle();
    sel = 1'b1; rd = 1'b1; mem_rdata = 8'hA3;
    #1;
    n_checks++;
    if (mem_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL fetch_addr: mem_addr=%0d expected 0", mem_addr);
    end
    ld_ir = 1'b1;
    tick();
    idle();
    #1;
    n_checks++;
    if (opcode !== 3'd5 || mem_addr !== 5'd3) begin
      n_fail++;
      $display("FAIL lda_decode: op=%0d addr=%0d expected 5 3", opcode, mem_addr);
    end
    load_dr(8'h80);
    ld_ac = 1'b1;
    tick();
    idle();
    n_checks++;
    if (ac !== 8'h80 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL lda_ac: ac=%h zero=%b expected 80 0", ac, zero);
    end
  endtask

  task automatic test_alu();
    // ADD with the carry dropped
    set_ac(8'hF0);
    load_ir(8'h40);
    load_dr(8'h20);
    ld_ac = 1'b1; tick(); idle();
    n_checks++;
    if (ac !== 8'h10 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL add_carry: ac=%h zero=%b expected 10 0", ac, zero);
    end
    // AND yields zero
    load_ir(8'h60);
    load_dr(8'h0F);
    ld_ac = 1'b1; tick(); idle();
    n_checks++;
    if (ac !== 8'h00 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL and_zero: ac=%h zero=%b expected 00 1", ac, zero);
    end
    // XOR
    set_ac(8'h5A);
    load_ir(8'h80);
    load_dr(8'hFF);
    ld_ac = 1'b1; tick(); idle();
    n_checks++;
    if (ac !== 8'hA5) begin
      n_fail++;
      $display("FAIL xor: ac=%h expected a5", ac);
    end
    // STO and HLT pass the AC through unchanged
    load_ir(8'hC0);
    load_dr(8'h33);
    ld_ac = 1'b1; tick(); idle();
    load_ir(8'h00);
    ld_ac = 1'b1; tick(); idle();
    n_checks++;
    if (ac !== 8'hA5) begin
      n_fail++;
      $display("FAIL passthru: ac=%h expected a5", ac);
    end
    // DR must ignore reads with sel=1 or with ld_ir=1
    load_ir(8'hA0);
    load_dr(8'h11);
    rd = 1'b1; sel = 1'b1; mem_rdata = 8'h77; tick(); idle();
    rd = 1'b1; sel = 1'b0; ld_ir = 1'b1; mem_rdata = 8'hA0; tick(); idle();
    ld_ac = 1'b1; tick(); idle();
    n_checks++;
    if (ac !== 8'h11) begin
      n_fail++;
      $display("FAIL dr_hold: ac=%h expected 11", ac);
    end
  endtask

  task automatic test_skz();
    set_ac(8'h00);
    set_pc(5'd4);
    load_ir(8'h20);
    inc_pc = 1'b1; tick(); idle();
    n_checks++;
    if (pc !== 5'd6) begin
      n_fail++;
      $display("FAIL skz_taken: pc=%0d expected 6", pc);
    end
    set_ac(8'h01);
    set_pc(5'd4);
    load_ir(8'h20);
    inc_pc = 1'b1; tick(); idle();
    n_checks++;
    if (pc !== 5'd5) begin
      n_fail++;
      $display("FAIL skz_not_taken: pc=%0d expected 5", pc);
    end
    set_ac(8'h00);
    set_pc(5'd31);
    load_ir(8'h20);
    inc_pc = 1'b1; tick(); idle();
    n_checks++;
    if (pc !== 5'd1) begin
      n_fail++;
      $display("FAIL skz_wrap31: pc=%0d expected 1", pc);
    end
    set_pc(5'd30);
    load_ir(8'h20);
    inc_pc = 1'b1; tick(); idle();
    n_checks++;
    if (pc !== 5'd0) begin
      n_fail++;
      $display("FAIL skz_wrap30: pc=%0d expected 0", pc);
    end
    // A plain increment wraps 31 -> 0 (AC is still zero, but IR is not SKZ).
    set_pc(5'd31);
    load_ir(8'h40);
    inc_pc = 1'b1; tick(); idle();
    n_checks++;
    if (pc !== 5'd0) begin
      n_fail++;
      $display("FAIL inc_wrap: pc=%0d expected 0", pc);
    end
  endtask

  task automatic test_jmp_priority();
    set_pc(5'd3);
    load_ir(8'hF1);
    ld_pc = 1'b1; inc_pc = 1'b1; tick(); idle();
    n_checks++;
    if (pc !== 5'h11) begin
      n_fail++;
      $display("FAIL jmp_priority: pc=%h expected 11", pc);
    end
  endtask

  task automatic test_store();
    set_ac(8'h5A);
    load_ir(8'hC9);
    sel = 1'b0; wr = 1'b1; data_e = 1'b1;
    #1;
    n_checks++;
    if (mem_addr !== 5'd9 || mem_we !== 1'b1 || mem_wdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL store: addr=%0d we=%b wdata=%h expected 9 1 5a",
               mem_addr, mem_we, mem_wdata);
    end
    data_e = 1'b0;
    #1;
    n_checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL store_no_data_e: we=%b wdata=%h expected 1 00", mem_we, mem_wdata);
    end
    idle();
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
      n_fail++;
      $display("FAIL strobes_idle: we=%b re=%b expected 0 0", mem_we, mem_re);
    end
  endtask

  task automatic test_back_to_back();
    // ld_ir and ld_ac on the same edge: AC must use the old (ADD) opcode.
    set_ac(8'h10);
    load_ir(8'h40);
    load_dr(8'h05);
    sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; ld_ac = 1'b1; mem_rdata = 8'hA7;
    tick(); idle();
    n_checks++;
    if (ac !== 8'h15 || opcode !== 3'd5) begin
      n_fail++;
      $display("FAIL ir_ac_same_edge: ac=%h op=%0d expected 15 5", ac, opcode);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    #1;
    n_checks++;
    if (pc !== 5'd0 || ac !== 8'h00 || opcode !== 3'd0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL initial_reset: pc=%0d ac=%h op=%0d zero=%b expected 0 00 0 1",
               pc, ac, opcode, zero);
    end
    test_reset();
    test_lda();
    test_alu();
    test_skz();
    test_jmp_priority();
    test_store();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
